// File: rtl/pcs_tx_lane_serializer.sv
// N-lane to 1 coded-block serializer for the PCS TX path. A slow-valid shadow register feeds a
// working register that is emitted one lane per fast valid, in a programmable rotated order.
module pcs_tx_lane_serializer #(
  parameter int unsigned NB_DATA_CODED = 66,
  parameter int unsigned N_LANES       = 20,
  parameter int unsigned NB_LANE_IDX   = 5
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_enable,
  input  logic                              i_valid,
  input  logic                              i_set_shadow,
  input  logic [NB_DATA_CODED*N_LANES-1:0]  i_data,
  input  logic [NB_LANE_IDX-1:0]            i_rf_lane_offset,
  input  logic                              i_rf_reverse,
  input  logic                              i_rf_clear_errors,
  output logic [NB_DATA_CODED-1:0]          o_data,
  output logic                              o_valid,
  output logic                              o_sol,
  output logic [NB_LANE_IDX-1:0]            o_lane_idx,
  output logic                              o_overrun,
  output logic                              o_underrun
);

  localparam int unsigned NB_BUS = NB_DATA_CODED * N_LANES;
  localparam logic [NB_LANE_IDX:0] N_LANES_EXT = (NB_LANE_IDX + 1)'(N_LANES);
  localparam logic [NB_LANE_IDX-1:0] LAST_CNT = NB_LANE_IDX'(N_LANES - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                   state_q, state_d;
  logic [NB_BUS-1:0]        shadow_q, shadow_d;
  logic                     shadow_full_q, shadow_full_d;
  logic [NB_BUS-1:0]        working_q, working_d;
  logic [NB_LANE_IDX-1:0]   cnt_q, cnt_d;
  logic [NB_LANE_IDX-1:0]   offset_q, offset_d;
  logic                     reverse_q, reverse_d;
  logic [NB_DATA_CODED-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     sol_q, sol_d;
  logic [NB_LANE_IDX-1:0]   lane_idx_q, lane_idx_d;
  logic                     overrun_q, overrun_d;
  logic                     underrun_q, underrun_d;

  logic [NB_DATA_CODED-1:0] work_lanes [N_LANES];
  logic [NB_LANE_IDX:0]     lane_sum;
  logic [NB_LANE_IDX-1:0]   lane;
  logic [NB_DATA_CODED-1:0] lane_data;
  logic [NB_LANE_IDX-1:0]   sel_offset;
  logic                     xfer, bypass, overrun_set, underrun_set;

  // Lane 0 sits in the most significant slice of the bus.
  for (genvar g = 0; g < N_LANES; g++) begin : g_lanes
    assign work_lanes[g] = working_q[NB_BUS - 1 - g * NB_DATA_CODED -: NB_DATA_CODED];
  end

  // One extra bit keeps offset +/- cnt free of wrap artefacts before the modulo fold.
  always_comb begin
    if (reverse_q) begin
      lane_sum = {1'b0, offset_q} + N_LANES_EXT - {1'b0, cnt_q};
    end else begin
      lane_sum = {1'b0, offset_q} + {1'b0, cnt_q};
    end
    if (lane_sum >= N_LANES_EXT) begin
      lane_sum = lane_sum - N_LANES_EXT;
    end
    lane = lane_sum[NB_LANE_IDX-1:0];
    lane_data = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (lane == NB_LANE_IDX'(k)) begin
        lane_data = work_lanes[k];
      end
    end
  end

  assign sel_offset = ({1'b0, i_rf_lane_offset} >= N_LANES_EXT) ? '0 : i_rf_lane_offset;

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    working_d     = working_q;
    cnt_d         = cnt_q;
    offset_d      = offset_q;
    reverse_d     = reverse_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    sol_d         = 1'b0;
    lane_idx_d    = lane_idx_q;
    overrun_d     = overrun_q;
    underrun_d    = underrun_q;
    xfer          = 1'b0;
    bypass        = 1'b0;
    overrun_set   = 1'b0;
    underrun_set  = 1'b0;

    if (i_enable) begin
      case (state_q)
        StIdle: begin
          if (shadow_full_q) begin
            xfer    = 1'b1;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (i_valid) begin
            data_d     = lane_data;
            lane_idx_d = lane;
            valid_d    = 1'b1;
            sol_d      = (cnt_q == '0);
            if (cnt_q == LAST_CNT) begin
              cnt_d = '0;
              if (shadow_full_q) begin
                xfer = 1'b1;
              end else if (i_set_shadow) begin
                bypass = 1'b1;
              end else begin
                underrun_set = 1'b1;
                state_d      = StIdle;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (xfer) begin
        working_d     = shadow_q;
        shadow_full_d = i_set_shadow;
      end else if (bypass) begin
        working_d = i_data;
      end else if (i_set_shadow) begin
        overrun_set   = shadow_full_q;
        shadow_full_d = 1'b1;
      end

      // A bypass consumes i_data directly, so the shadow stays empty.
      if (i_set_shadow && !bypass) begin
        shadow_d = i_data;
      end

      if (xfer || bypass) begin
        offset_d  = sel_offset;
        reverse_d = i_rf_reverse;
      end

      overrun_d  = overrun_set | (overrun_q & ~i_rf_clear_errors);
      underrun_d = underrun_set | (underrun_q & ~i_rf_clear_errors);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= StIdle;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      working_q     <= '0;
      cnt_q         <= '0;
      offset_q      <= '0;
      reverse_q     <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      sol_q         <= 1'b0;
      lane_idx_q    <= '0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      working_q     <= working_d;
      cnt_q         <= cnt_d;
      offset_q      <= offset_d;
      reverse_q     <= reverse_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      sol_q         <= sol_d;
      lane_idx_q    <= lane_idx_d;
      overrun_q     <= overrun_d;
      underrun_q    <= underrun_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_sol      = sol_q;
  assign o_lane_idx = lane_idx_q;
  assign o_overrun  = overrun_q;
  assign o_underrun = underrun_q;

endmodule
